idma_obi_write_ot: RTL and testbench
====================================

Name: idma_obi_write_ot

Overview:
- Next-generation OBI write port for the iDMA transport layer.
- Drains the byte-granular realignment buffer into multi-beat OBI write bursts.
- Keeps up to NumOutstanding writes in flight.
- Counts OBI responses per burst and returns one write-datapath response per burst, carrying a sticky error flag.
- Sits between the write barrel shifter output and the OBI manager port. Replaces the single-outstanding write port in OBI-target transport layers.

Parameters:
- DataWidth, 32: OBI data width in bits, power of two, >=16; StrbWidth = DataWidth/8.
- AddrWidth, 32: OBI address width.
- LenWidth, 8: burst length field width (beats-1).
- NumOutstanding, 4: max OBI beats granted but not yet answered, plus completed-but-unacknowledged burst responses; >=1.
- MaskInvalidData, 1: drive wdata bytes with be=0 to 8'h00.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low (sampled on rising clk_i edge)
- aw_addr_i  in  AddrWidth  burst start byte address
- aw_len_i  in  LenWidth  beats-1
- aw_first_strb_i  in  StrbWidth  byte mask of first beat
- aw_last_strb_i  in  StrbWidth  byte mask of last beat
- aw_valid_i / aw_ready_o  in/out  1  burst meta handshake
- buffer_data_i  in  DataWidth  shifted buffer output bytes
- buffer_valid_i  in  StrbWidth  per-byte valid
- buffer_ready_o  out  StrbWidth  per-byte pop
- obi_req_o, obi_we_o  out  1  OBI A-channel request; we=1 always
- obi_addr_o  out  AddrWidth  word-aligned address
- obi_wdata_o  out  DataWidth  write data
- obi_be_o  out  StrbWidth  byte enables
- obi_gnt_i  in  1  OBI grant
- obi_rvalid_i  in  1  OBI response valid
- obi_err_i  in  1  OBI response error
- w_rsp_valid_o / w_rsp_ready_i  out/in  1  per-burst response handshake
- w_rsp_error_o  out  1  OR of obi_err_i over all beats of the burst
- busy_o  out  1  any burst active, beat outstanding or response pending

Behaviour:
- Reset (rst_ni=0 at an edge): FSM=IDLE; beat counter, outstanding counter, length FIFO and response FIFO cleared.
- Outputs after reset: obi_req_o=0, buffer_ready_o=0, aw_ready_o=1, w_rsp_valid_o=0, busy_o=0.
- Reset mid-burst discards all state. rvalids arriving while outstanding_q==0 are ignored (simulation assertion fires).
- FSM IDLE:
  - aw_ready_o=1 iff length FIFO (depth NumOutstanding) not full.
  - On aw handshake: latch addr/len/strbs, push len into length FIFO, beat_q=0, go BURST.
- FSM BURST:
  - be = first_strb on beat 0, last_strb on beat len, first&last when len=0, all-ones otherwise.
  - obi_addr_o = {addr_q[AddrWidth-1:log2 StrbWidth] + beat_q, zeros}.
  - Issue condition: (buffer_valid_i & be)==be and outstanding_q + rsp_cnt < NumOutstanding.
  - Once obi_req_o rises, req/addr/wdata/be stay stable until obi_gnt_i (OBI rule). No withdrawal; the issue condition is not re-evaluated while waiting.
  - On req&gnt: buffer_ready_o=be in that same cycle only; beat_q++.
  - If beat_q==len, go IDLE. aw may be accepted in the same cycle the last beat is granted (zero-bubble back-to-back).
- Outstanding counter: +1 on req&gnt, -1 on rvalid; both in one cycle leaves it unchanged.
- Response side:
  - rsp_beat_q counts rvalids against the length FIFO head; err_q |= obi_err_i.
  - When rsp_beat_q == head len on an rvalid: pop length FIFO, push {err} into response FIFO (depth NumOutstanding), clear counters.
  - The gating rule above guarantees the response FIFO never overflows.
  - w_rsp_valid_o = response FIFO not empty; pop on w_rsp_ready_i.
- Data masking: obi_wdata_o byte i = buffer_data_i byte i if be[i], else 0 when MaskInvalidData=1.
- Latency: first obi_req_o no earlier than one cycle after the aw handshake. Response valid one cycle after the final rvalid.
- busy_o = FSM!=IDLE | outstanding_q!=0 | length FIFO non-empty | response FIFO non-empty.

Test Plan:
- Single beat:
  - Stimulus: aw addr=0x100, len=0, strbs=4'hF; buffer full; gnt same cycle; rvalid next cycle.
  - Required: one req with addr 0x100, be=F; buffer_ready=F for one cycle; w_rsp_valid one cycle after rvalid, error=0.
- Misaligned 3-beat:
  - Stimulus: addr=0x102, len=2, first=4'hC, last=4'h3.
  - Required: addrs 0x100/0x104/0x108; be C/F/3; wdata masked bytes = 0.
- Grant stall:
  - Stimulus: gnt low 5 cycles with buffer_valid toggling.
  - Required: req/addr/wdata/be constant; buffer_ready=0 until the gnt cycle.
- Outstanding limit:
  - Stimulus: NumOutstanding=4, len=7, gnt=1, rvalid withheld.
  - Required: exactly 4 beats granted, then req=0. Each rvalid releases one beat; 8 rvalids in total yield a single response.
- Error and back-pressure:
  - Stimulus: two len=1 bursts; beat 1 of burst A returns err=1; w_rsp_ready=0 for 10 cycles.
  - Required: two queued responses A(err=1), B(err=0) popped in order. No beat is issued while outstanding_q + rsp_cnt >= 4.
- Reset mid-burst:
  - Stimulus: assert rst_ni=0 after beat 2 of len=5.
  - Required: next edge gives req=0, aw_ready=1, busy=0. Then a new burst completes normally.

Source files
------------

// File: rtl/idma_obi_write_ot.sv
// OBI write port for the iDMA transport layer: drains the realignment buffer
// into multi-beat OBI write bursts and returns one response per burst.
//
// state | meaning
// IDLE  | no burst being issued; aw accepted if the length FIFO has room
// BURST | issuing beats of the current burst on the OBI A channel
module idma_obi_write_ot #(
  parameter int unsigned DataWidth       = 32,
  parameter int unsigned AddrWidth       = 32,
  parameter int unsigned LenWidth        = 8,
  parameter int unsigned NumOutstanding  = 4,
  parameter bit          MaskInvalidData = 1'b1,
  localparam int unsigned StrbWidth      = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic [LenWidth-1:0]  aw_len_i,
  input  logic [StrbWidth-1:0] aw_first_strb_i,
  input  logic [StrbWidth-1:0] aw_last_strb_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [DataWidth-1:0] buffer_data_i,
  input  logic [StrbWidth-1:0] buffer_valid_i,
  output logic [StrbWidth-1:0] buffer_ready_o,
  output logic                 obi_req_o,
  output logic                 obi_we_o,
  output logic [AddrWidth-1:0] obi_addr_o,
  output logic [DataWidth-1:0] obi_wdata_o,
  output logic [StrbWidth-1:0] obi_be_o,
  input  logic                 obi_gnt_i,
  input  logic                 obi_rvalid_i,
  input  logic                 obi_err_i,
  output logic                 w_rsp_valid_o,
  input  logic                 w_rsp_ready_i,
  output logic                 w_rsp_error_o,
  output logic                 busy_o
);

  localparam int unsigned OffWidth  = $clog2(StrbWidth);
  localparam int unsigned WordWidth = AddrWidth - OffWidth;
  localparam int unsigned PtrWidth  = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
  localparam int unsigned CntWidth  = $clog2(NumOutstanding + 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e               state_q;
  logic [WordWidth-1:0] word_q;
  logic [LenWidth-1:0]  len_q, beat_q;
  logic [StrbWidth-1:0] first_strb_q, last_strb_q;
  logic                 hold_q;
  logic [DataWidth-1:0] wdata_q;
  logic [CntWidth-1:0]  outstanding_q;

  logic [LenWidth-1:0]       len_fifo_q [NumOutstanding];
  logic [PtrWidth-1:0]       len_wr_q, len_rd_q;
  logic [CntWidth-1:0]       len_cnt_q;
  logic [NumOutstanding-1:0] rsp_fifo_q;
  logic [PtrWidth-1:0]       rsp_wr_q, rsp_rd_q;
  logic [CntWidth-1:0]       rsp_cnt_q;
  logic [LenWidth-1:0]       rsp_beat_q;
  logic                      err_q;

  logic                 is_first, is_last, data_ok, credit_ok;
  logic                 beat_hs, aw_hs, rsp_in, burst_done, rsp_pop, err_acc;
  logic [StrbWidth-1:0] be;
  logic [DataWidth-1:0] wdata_masked;
  logic [CntWidth:0]    inflight;
  logic [WordWidth-1:0] word_addr;
  logic                 unused_addr_offset;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(NumOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  // The byte offset is already encoded in the first-beat strobe.
  assign unused_addr_offset = ^aw_addr_i[OffWidth-1:0];

  assign is_first  = (beat_q == '0);
  assign is_last   = (beat_q == len_q);
  assign be        = (is_first ? first_strb_q : {StrbWidth{1'b1}})
                   & (is_last  ? last_strb_q  : {StrbWidth{1'b1}});
  assign word_addr = word_q + WordWidth'(beat_q);
  assign inflight  = {1'b0, outstanding_q} + {1'b0, rsp_cnt_q};
  assign credit_ok = inflight < (CntWidth + 1)'(NumOutstanding);
  assign data_ok   = (buffer_valid_i & be) == be;

  always_comb begin
    wdata_masked = buffer_data_i;
    if (MaskInvalidData) begin
      for (int i = 0; i < StrbWidth; i++) begin
        if (!be[i]) wdata_masked[8*i +: 8] = 8'h00;
      end
    end
  end

  // Once raised, req is held from the latched beat without re-checking the issue condition.
  assign obi_req_o      = (state_q == BURST) && (hold_q || (data_ok && credit_ok));
  assign obi_we_o       = 1'b1;
  assign obi_addr_o     = {word_addr, {OffWidth{1'b0}}};
  assign obi_wdata_o    = hold_q ? wdata_q : wdata_masked;
  assign obi_be_o       = be;
  assign beat_hs        = obi_req_o && obi_gnt_i;
  assign buffer_ready_o = beat_hs ? be : '0;

  assign aw_ready_o = (len_cnt_q != CntWidth'(NumOutstanding))
                   && ((state_q == IDLE) || (beat_hs && is_last));
  assign aw_hs      = aw_valid_i && aw_ready_o;

  assign rsp_in        = obi_rvalid_i && (outstanding_q != '0);
  assign err_acc       = err_q | obi_err_i;
  assign burst_done    = rsp_in && (rsp_beat_q == len_fifo_q[len_rd_q]);
  assign w_rsp_valid_o = (rsp_cnt_q != '0);
  assign w_rsp_error_o = rsp_fifo_q[rsp_rd_q];
  assign rsp_pop       = w_rsp_valid_o && w_rsp_ready_i;

  assign busy_o = (state_q != IDLE) || (outstanding_q != '0)
               || (len_cnt_q != '0) || (rsp_cnt_q != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      word_q       <= '0;
      len_q        <= '0;
      first_strb_q <= '0;
      last_strb_q  <= '0;
      beat_q       <= '0;
      hold_q       <= 1'b0;
      wdata_q      <= '0;
    end else begin
      if (aw_hs) begin
        word_q       <= aw_addr_i[AddrWidth-1:OffWidth];
        len_q        <= aw_len_i;
        first_strb_q <= aw_first_strb_i;
        last_strb_q  <= aw_last_strb_i;
        beat_q       <= '0;
      end
      case (state_q)
        IDLE: begin
          if (aw_hs) state_q <= BURST;
        end
        BURST: begin
          if (beat_hs) begin
            hold_q <= 1'b0;
            if (!is_last)    beat_q  <= beat_q + 1'b1;
            else if (!aw_hs) state_q <= IDLE;
          end else if (obi_req_o && !hold_q) begin
            hold_q  <= 1'b1;
            wdata_q <= wdata_masked;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
      len_wr_q      <= '0;
      len_rd_q      <= '0;
      len_cnt_q     <= '0;
      rsp_fifo_q    <= '0;
      rsp_wr_q      <= '0;
      rsp_rd_q      <= '0;
      rsp_cnt_q     <= '0;
      rsp_beat_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      case ({beat_hs, rsp_in})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: ;
      endcase

      if (aw_hs) begin
        len_fifo_q[len_wr_q] <= aw_len_i;
        len_wr_q             <= ptr_inc(len_wr_q);
      end
      if (burst_done) len_rd_q <= ptr_inc(len_rd_q);
      case ({aw_hs, burst_done})
        2'b10:   len_cnt_q <= len_cnt_q + 1'b1;
        2'b01:   len_cnt_q <= len_cnt_q - 1'b1;
        default: ;
      endcase

      if (rsp_in) begin
        if (burst_done) begin
          rsp_beat_q <= '0;
          err_q      <= 1'b0;
        end else begin
          rsp_beat_q <= rsp_beat_q + 1'b1;
          err_q      <= err_acc;
        end
      end

      // Credit gating keeps outstanding + queued responses <= NumOutstanding, so no overflow.
      if (burst_done) begin
        rsp_fifo_q[rsp_wr_q] <= err_acc;
        rsp_wr_q             <= ptr_inc(rsp_wr_q);
      end
      if (rsp_pop) rsp_rd_q <= ptr_inc(rsp_rd_q);
      case ({burst_done, rsp_pop})
        2'b10:   rsp_cnt_q <= rsp_cnt_q + 1'b1;
        2'b01:   rsp_cnt_q <= rsp_cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) assert (!(obi_rvalid_i && outstanding_q == '0));
  end

endmodule

// File: tb/tb_idma_obi_write_ot.sv
// Directed bench for idma_obi_write_ot: single beat, misaligned burst, grant
// stall, outstanding limit, error/back-pressure and reset mid-burst.
module tb_idma_obi_write_ot;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [3:0]  aw_first_strb, aw_last_strb;
  logic        aw_valid, aw_ready;
  logic [31:0] buffer_data;
  logic [3:0]  buffer_valid, buffer_ready;
  logic        obi_req, obi_we;
  logic [31:0] obi_addr, obi_wdata;
  logic [3:0]  obi_be;
  logic        obi_gnt, obi_rvalid, obi_err;
  logic        w_rsp_valid, w_rsp_ready, w_rsp_error;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int grants;

  idma_obi_write_ot dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .aw_addr_i      (aw_addr),
    .aw_len_i       (aw_len),
    .aw_first_strb_i(aw_first_strb),
    .aw_last_strb_i (aw_last_strb),
    .aw_valid_i     (aw_valid),
    .aw_ready_o     (aw_ready),
    .buffer_data_i  (buffer_data),
    .buffer_valid_i (buffer_valid),
    .buffer_ready_o (buffer_ready),
    .obi_req_o      (obi_req),
    .obi_we_o       (obi_we),
    .obi_addr_o     (obi_addr),
    .obi_wdata_o    (obi_wdata),
    .obi_be_o       (obi_be),
    .obi_gnt_i      (obi_gnt),
    .obi_rvalid_i   (obi_rvalid),
    .obi_err_i      (obi_err),
    .w_rsp_valid_o  (w_rsp_valid),
    .w_rsp_ready_i  (w_rsp_ready),
    .w_rsp_error_o  (w_rsp_error),
    .busy_o         (busy)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_aw(input logic [31:0] a, input logic [7:0] l,
                       input logic [3:0] f, input logic [3:0] ls);
    aw_addr = a; aw_len = l; aw_first_strb = f; aw_last_strb = ls; aw_valid = 1'b1;
    #1 chk("aw_ready_idle", aw_ready, 1'b1);
    tick();
    aw_valid = 1'b0;
  endtask

  task automatic pop_rsp(input logic exp_err);
    w_rsp_ready = 1'b0;
    #1 chk("rsp_valid", w_rsp_valid, 1'b1);
    chk("rsp_error", w_rsp_error, exp_err);
    w_rsp_ready = 1'b1;
    tick();
    w_rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; aw_addr = '0; aw_len = '0; aw_first_strb = '0; aw_last_strb = '0;
    aw_valid = 1'b0; buffer_data = '0; buffer_valid = '0; obi_gnt = 1'b0;
    obi_rvalid = 1'b0; obi_err = 1'b0; w_rsp_ready = 1'b0;
    tick(); tick();
    #1 chk("rst_req", obi_req, 1'b0);
    chk("rst_bready", buffer_ready, 4'h0);
    chk("rst_aw_ready", aw_ready, 1'b1);
    chk("rst_rsp_valid", w_rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_ni = 1'b1;
    tick();

    // single beat
    buffer_data = 32'h1122_3344; buffer_valid = 4'hF; obi_gnt = 1'b1;
    do_aw(32'h100, 8'd0, 4'hF, 4'hF);
    #1 chk("sb_req", obi_req, 1'b1);
    chk("sb_we", obi_we, 1'b1);
    chk("sb_addr", obi_addr, 32'h100);
    chk("sb_be", obi_be, 4'hF);
    chk("sb_wdata", obi_wdata, 32'h1122_3344);
    chk("sb_bready", buffer_ready, 4'hF);
    tick();
    obi_gnt = 1'b0; obi_rvalid = 1'b1;
    #1 chk("sb_req_after", obi_req, 1'b0);
    chk("sb_bready_after", buffer_ready, 4'h0);
    chk("sb_rsp_early", w_rsp_valid, 1'b0);
    chk("sb_busy", busy, 1'b1);
    tick();
    obi_rvalid = 1'b0;
    pop_rsp(1'b0);
    #1 chk("sb_idle", busy, 1'b0);

    // misaligned 3-beat
    buffer_data = 32'hAABB_CCDD; obi_gnt = 1'b1;
    do_aw(32'h102, 8'd2, 4'hC, 4'h3);
    #1 chk("mis_addr0", obi_addr, 32'h100);
    chk("mis_be0", obi_be, 4'hC);
    chk("mis_wdata0", obi_wdata, 32'hAABB_0000);
    tick();
    #1 chk("mis_addr1", obi_addr, 32'h104);
    chk("mis_be1", obi_be, 4'hF);
    chk("mis_wdata1", obi_wdata, 32'hAABB_CCDD);
    tick();
    #1 chk("mis_addr2", obi_addr, 32'h108);
    chk("mis_be2", obi_be, 4'h3);
    chk("mis_wdata2", obi_wdata, 32'h0000_CCDD);
    tick();
    obi_gnt = 1'b0; obi_rvalid = 1'b1;
    tick(); tick();
    #1 chk("mis_rsp_early", w_rsp_valid, 1'b0);
    tick();
    obi_rvalid = 1'b0;
    pop_rsp(1'b0);

    // grant stall
    buffer_data = 32'h5566_7788; buffer_valid = 4'hF; obi_gnt = 1'b0;
    do_aw(32'h200, 8'd0, 4'hF, 4'hF);
    #1 chk("st_req0", obi_req, 1'b1);
    chk("st_bready0", buffer_ready, 4'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      buffer_valid = (i % 2 == 0) ? 4'h0 : 4'hF;
      buffer_data  = 32'hDEAD_0000 | 32'(i);
      #1 chk("st_req", obi_req, 1'b1);
      chk("st_addr", obi_addr, 32'h200);
      chk("st_be", obi_be, 4'hF);
      chk("st_wdata", obi_wdata, 32'h5566_7788);
      chk("st_bready", buffer_ready, 4'h0);
      tick();
    end
    buffer_data = 32'h5566_7788; buffer_valid = 4'hF; obi_gnt = 1'b1;
    #1 chk("st_gnt_bready", buffer_ready, 4'hF);
    chk("st_gnt_wdata", obi_wdata, 32'h5566_7788);
    tick();
    obi_gnt = 1'b0; obi_rvalid = 1'b1;
    tick();
    obi_rvalid = 1'b0;
    pop_rsp(1'b0);

    // outstanding limit
    buffer_data = 32'h0102_0304; buffer_valid = 4'hF; obi_gnt = 1'b1;
    do_aw(32'h300, 8'd7, 4'hF, 4'hF);
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      #1 if (obi_req && obi_gnt) grants++;
      tick();
    end
    chk("ol_grants", grants, 4);
    #1 chk("ol_req_blocked", obi_req, 1'b0);
    for (int k = 0; k < 4; k++) begin
      obi_rvalid = 1'b1;
      #1 chk("ol_req_full", obi_req, 1'b0);
      tick();
      obi_rvalid = 1'b0;
      #1 chk("ol_req_release", obi_req, 1'b1);
      chk("ol_addr", obi_addr, 32'h310 + 32'(4 * k));
      tick();
    end
    #1 chk("ol_req_done", obi_req, 1'b0);
    obi_rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("ol_rsp_early", w_rsp_valid, 1'b0);
      tick();
    end
    obi_rvalid = 1'b0;
    pop_rsp(1'b0);
    #1 chk("ol_single_rsp", w_rsp_valid, 1'b0);
    chk("ol_idle", busy, 1'b0);

    // error and back-pressure
    obi_gnt = 1'b1;
    do_aw(32'h400, 8'd1, 4'hF, 4'hF);
    aw_addr = 32'h500; aw_len = 8'd1; aw_valid = 1'b1;
    #1 chk("eb_aw_busy", aw_ready, 1'b0);
    chk("eb_addrA0", obi_addr, 32'h400);
    tick();
    #1 chk("eb_aw_zero_bubble", aw_ready, 1'b1);
    chk("eb_addrA1", obi_addr, 32'h404);
    tick();
    aw_valid = 1'b0;
    #1 chk("eb_addrB0", obi_addr, 32'h500);
    tick();
    #1 chk("eb_addrB1", obi_addr, 32'h504);
    tick();
    obi_rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      obi_err = (i == 1);
      tick();
    end
    obi_rvalid = 1'b0; obi_err = 1'b0;
    do_aw(32'h600, 8'd3, 4'hF, 4'hF);
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      #1 if (obi_req && obi_gnt) grants++;
      tick();
    end
    chk("eb_grants_gated", grants, 2);
    #1 chk("eb_req_gated", obi_req, 1'b0);
    obi_gnt = 1'b0;
    pop_rsp(1'b1);
    pop_rsp(1'b0);
    #1 chk("eb_rsp_drained", w_rsp_valid, 1'b0);
    obi_gnt = 1'b1;
    grants = 0;
    for (int i = 0; i < 4; i++) begin
      #1 if (obi_req && obi_gnt) grants++;
      tick();
    end
    chk("eb_grants_rest", grants, 2);
    obi_gnt = 1'b0; obi_rvalid = 1'b1;
    tick(); tick(); tick(); tick();
    obi_rvalid = 1'b0;
    pop_rsp(1'b0);
    #1 chk("eb_idle", busy, 1'b0);

    // reset mid-burst
    obi_gnt = 1'b1;
    do_aw(32'h700, 8'd5, 4'hF, 4'hF);
    tick(); tick(); tick();
    rst_ni = 1'b0;
    tick();
    #1 chk("rm_req", obi_req, 1'b0);
    chk("rm_aw_ready", aw_ready, 1'b1);
    chk("rm_busy", busy, 1'b0);
    chk("rm_bready", buffer_ready, 4'h0);
    rst_ni = 1'b1;
    tick();
    do_aw(32'h800, 8'd1, 4'hF, 4'hF);
    #1 chk("rm_new_addr0", obi_addr, 32'h800);
    tick();
    #1 chk("rm_new_addr1", obi_addr, 32'h804);
    tick();
    obi_gnt = 1'b0; obi_rvalid = 1'b1;
    tick(); tick();
    obi_rvalid = 1'b0;
    pop_rsp(1'b0);
    #1 chk("rm_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
